pq_sched: RTL and testbench
===========================

Name: pq_sched

Overview:
- Controller in front of the array priority queue. Arbitrates push requests from N_REQ requesters round-robin and issues drop-by-id commands.
- Keeps a free-running time base. Pops the head cell when its timestamp is due and presents the popped cell on a valid/ready expiry port.
- Issues at most one queue op per two cycles: op cycle followed by a mandatory settle cycle.

Parameters:
- N_REQ, 4, number of push requesters (>=1).
- TIME_WIDTH, pq_pkg::TIME_WIDTH (24), timestamp and now counter width.
- LATE_CNT_WIDTH, 16, width of the optional late-expiry counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- tick_i  in  1  advance now counter by 1 this cycle
- now_o  out  TIME_WIDTH  current time
- req_valid_i  in  N_REQ  push request per requester
- req_cell_i  in  N_REQ x cell_t  cell to push, per requester
- req_ready_o  out  N_REQ  one-hot grant; push accepted when valid & ready
- drop_valid_i  in  1  drop request
- drop_id_i  in  TIME_WIDTH  id to drop
- drop_ready_o  out  1  drop accepted
- q_push_o / q_pop_o / q_drop_o  out  1 each  queue op strobes, mutually exclusive
- q_cell_o  out  cell_t  push cell, or {0, drop_id, 0} for drop
- q_head_i  in  cell_t  current queue head
- q_empty_i / q_full_i  in  1 each  queue status
- exp_valid_o  out  1  expired cell available
- exp_cell_o  out  cell_t  expired cell
- exp_ready_i  in  1  consumer accepts expired cell
- late_cnt_o  out  LATE_CNT_WIDTH  late expiries (optional feature)

Behaviour:
- Reset values: all outputs 0, now 0, round-robin pointer 0, state IDLE, exp register empty.
- Reset is honoured in any state and discards an in-flight op. The queue's own reset is external.
- now: increments mod 2^TIME_WIDTH on cycles where tick_i=1.
- Due test, wrap-safe: diff = (now - q_head_i.data) mod 2^TIME_WIDTH; due when diff[TIME_WIDTH-1]==0, which includes equality.
- FSM states: IDLE, SETTLE.
- IDLE: at most one op per cycle, decided on registered inputs of that cycle, priority as follows:
  1. POP if !q_empty_i & due & exp register empty. Assert q_pop_o; latch q_head_i into the exp register (exp_valid_o=1 next cycle).
  2. else DROP if drop_valid_i. Assert q_drop_o and drop_ready_o.
  3. else PUSH if any req_valid_i & !q_full_i. Round-robin grant starting at pointer; assert the granted req_ready_o and q_push_o, with q_cell_o = granted cell. Pointer becomes grant+1 mod N_REQ.
  - Any op issued -> SETTLE. No op -> remain in IDLE.
- SETTLE: no strobes, no readies; -> IDLE next cycle. Queue status and head are trusted only after this cycle.
- Strobes and readies are combinational from IDLE-state conditions and are 1-cycle pulses. The producer must hold valid and data until ready.
- Drop of an absent id is passed through; the queue ignores it. No response port.
- Exp register: exp_valid_o held with stable exp_cell_o until exp_ready_i. Cleared on handshake.
- Exp register full blocks POP only; drops and pushes continue.
- Full queue: no grants, drops still allowed. Empty queue: no pop.
- Simultaneous due head, drop and push: pop wins; drop goes 2 cycles later, push 4 cycles later.

Optional Feature:
- PQ_SCHED_LATE_CNT_EN defined: late_cnt_o counts POPs where diff != 0 (head strictly earlier than now). Saturates at all-ones; cleared by reset.
- Undefined: counter logic is absent and late_cnt_o is tied to 0.

Decomposition:
- pq_pkg additions:
  - sched_state_t enum {IDLE, SETTLE}
  - N_REQ default constant
  - reuse of cell_t and op_t to log issued op in benches
- One sub-module, pq_rr_arb: parameterised N_REQ round-robin arbiter. Inputs: request vector, enable, pointer update. Outputs: one-hot grant and index.

Test Plan:
- Reset, then tick 5 cycles, idle -> now_o=5, all strobes 0, exp_valid_o=0.
- Push data=10 from req0, now=3 -> q_push_o one cycle, then SETTLE. At now=10 (tick every cycle): q_pop_o, exp_cell_o.data=10, late_cnt_o unchanged.
- All 4 requesters valid continuously, queue not full -> grants 0,1,2,3,0 on cycles 0,2,4,6,8.
- Head data=4, exp_ready_i=0, drop_valid_i=1 id=7, now=9 -> pop cycle 0, drop cycle 2. No second pop while exp_valid_o=1; with the feature on, late_cnt_o=1.
- now near wrap: head data=0xFFFFFE at now=0x000001 is due; head 0x000005 at now=0xFFFFF0 is not due.
- q_full_i=1 with req_valid_i=4'b0001 -> req_ready_o=0 indefinitely. Deassert full -> grant within 1 cycle. Assert rst_i during SETTLE -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/pq_pkg.sv
// Shared types for the array priority queue and its scheduler front end.
package pq_pkg;

  localparam int TIME_WIDTH  = 24;
  localparam int TAG_WIDTH   = 8;
  localparam int SCHED_N_REQ = 4;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [TIME_WIDTH-1:0] id;
    logic [TIME_WIDTH-1:0] data;
  } cell_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_DROP
  } op_t;

  typedef enum logic {
    IDLE,
    SETTLE
  } sched_state_t;

endpackage

// File: rtl/pq_rr_arb.sv
// Round-robin arbiter: search starts at the stored pointer, which moves past
// the granted index whenever upd_i is asserted.
module pq_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             en_i,
  input  logic             upd_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  int               cand_int;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = '0;
    cand_int = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_int = int'(ptr_q) + i;
      if (cand_int >= N_REQ) cand_int = cand_int - N_REQ;
      cand = IDX_W'(cand_int);
      if (en_i && !any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) ptr_d = (int'(idx_o) == N_REQ - 1) ? '0 : idx_o + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/pq_sched.sv
// Priority-queue scheduler: push arbitration, drops, due-time pops, expiry port.
// Optional late-expiry counter enabled by defining PQ_SCHED_LATE_CNT_EN.
module pq_sched
  import pq_pkg::*;
#(
  parameter int N_REQ          = SCHED_N_REQ,
  parameter int TIME_WIDTH     = pq_pkg::TIME_WIDTH,
  parameter int LATE_CNT_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      tick_i,
  output logic [TIME_WIDTH-1:0]     now_o,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  cell_t [N_REQ-1:0]         req_cell_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic                      drop_valid_i,
  input  logic [TIME_WIDTH-1:0]     drop_id_i,
  output logic                      drop_ready_o,
  output logic                      q_push_o,
  output logic                      q_pop_o,
  output logic                      q_drop_o,
  output cell_t                     q_cell_o,
  input  cell_t                     q_head_i,
  input  logic                      q_empty_i,
  input  logic                      q_full_i,
  output logic                      exp_valid_o,
  output cell_t                     exp_cell_o,
  input  logic                      exp_ready_i,
  output logic [LATE_CNT_WIDTH-1:0] late_cnt_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_t          state_q, state_d;
  logic [TIME_WIDTH-1:0] now_q;
  logic [TIME_WIDTH-1:0] diff;
  logic                  due;
  logic                  pop_ok;
  logic                  push_en;
  op_t                   op;
  logic [N_REQ-1:0]      gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_any;
  logic                  exp_valid_q;
  cell_t                 exp_cell_q;

  // Wrap-safe due test: head is due when (now - ts) is non-negative mod 2^W.
  always_comb begin
    diff    = now_q - q_head_i.data;
    due     = ~diff[TIME_WIDTH-1];
    pop_ok  = (state_q == IDLE) && !q_empty_i && due && !exp_valid_q;
    push_en = (state_q == IDLE) && !pop_ok && !drop_valid_i && !q_full_i;
  end

  pq_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (req_valid_i),
    .en_i  (push_en),
    .upd_i (q_push_o),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  always_comb begin
    state_d = state_q;
    op      = OP_NONE;
    unique case (state_q)
      IDLE: begin
        if (pop_ok)            op = OP_POP;
        else if (drop_valid_i) op = OP_DROP;
        else if (gnt_any)      op = OP_PUSH;
        if (op != OP_NONE) state_d = SETTLE;
      end
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    q_push_o     = (op == OP_PUSH);
    q_pop_o      = (op == OP_POP);
    q_drop_o     = (op == OP_DROP);
    drop_ready_o = q_drop_o;
    req_ready_o  = q_push_o ? gnt : '0;
    q_cell_o     = '0;
    if (q_push_o) begin
      q_cell_o = req_cell_i[gnt_idx];
    end else if (q_drop_o) begin
      q_cell_o.id = drop_id_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      now_q       <= '0;
      exp_valid_q <= 1'b0;
      exp_cell_q  <= '0;
    end else begin
      state_q <= state_d;
      if (tick_i) now_q <= now_q + 1'b1;
      if (q_pop_o) begin
        exp_valid_q <= 1'b1;
        exp_cell_q  <= q_head_i;
      end else if (exp_valid_q && exp_ready_i) begin
        exp_valid_q <= 1'b0;
      end
    end
  end

  assign now_o       = now_q;
  assign exp_valid_o = exp_valid_q;
  assign exp_cell_o  = exp_cell_q;

`ifdef PQ_SCHED_LATE_CNT_EN
  logic [LATE_CNT_WIDTH-1:0] late_q;

  function automatic logic [LATE_CNT_WIDTH-1:0] sat_inc(input logic [LATE_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A pop is late when the head timestamp is strictly behind now.
  always_ff @(posedge clk_i) begin
    if (rst_i)                         late_q <= '0;
    else if (q_pop_o && diff != '0)    late_q <= sat_inc(late_q);
  end

  assign late_cnt_o = late_q;
`else
  logic unused_diff;
  assign unused_diff = ^diff[TIME_WIDTH-2:0];
  assign late_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pq_sched.sv
// Directed bench for pq_sched; queue status/head are driven by hand.
module tb_pq_sched;
  import pq_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic [23:0]  now;
  logic [3:0]   req_valid;
  cell_t [3:0]  req_cell;
  logic [3:0]   req_ready;
  logic         drop_valid;
  logic [23:0]  drop_id;
  logic         drop_ready;
  logic         q_push, q_pop, q_drop;
  cell_t        q_cell;
  cell_t        q_head;
  logic         q_empty, q_full;
  logic         exp_valid;
  cell_t        exp_cell;
  logic         exp_ready;
  logic [15:0]  late_cnt;

  int n_cmp = 0;
  int n_err = 0;

`ifdef PQ_SCHED_LATE_CNT_EN
  localparam logic [15:0] LATE_ONE = 16'd1;
`else
  localparam logic [15:0] LATE_ONE = 16'd0;
`endif

  always #5 clk = ~clk;

  pq_sched dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .tick_i       (tick),
    .now_o        (now),
    .req_valid_i  (req_valid),
    .req_cell_i   (req_cell),
    .req_ready_o  (req_ready),
    .drop_valid_i (drop_valid),
    .drop_id_i    (drop_id),
    .drop_ready_o (drop_ready),
    .q_push_o     (q_push),
    .q_pop_o      (q_pop),
    .q_drop_o     (q_drop),
    .q_cell_o     (q_cell),
    .q_head_i     (q_head),
    .q_empty_i    (q_empty),
    .q_full_i     (q_full),
    .exp_valid_o  (exp_valid),
    .exp_cell_o   (exp_cell),
    .exp_ready_i  (exp_ready),
    .late_cnt_o   (late_cnt)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tick = 1'b0; req_valid = '0; req_cell = '0;
    drop_valid = 1'b0; drop_id = '0; q_head = '0;
    q_empty = 1'b1; q_full = 1'b0; exp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (now !== 24'd0) begin n_err++; $display("FAIL reset_now: got %0d want 0", now); end
    n_cmp++; if ({q_push, q_pop, q_drop, drop_ready, req_ready} !== 8'd0) begin n_err++; $display("FAIL reset_strobes: got %b want 0", {q_push, q_pop, q_drop, drop_ready, req_ready}); end
    n_cmp++; if (exp_valid !== 1'b0) begin n_err++; $display("FAIL reset_exp_valid: got %b want 0", exp_valid); end
    n_cmp++; if (late_cnt !== 16'd0) begin n_err++; $display("FAIL reset_late: got %0d want 0", late_cnt); end
    tick = 1'b1;
    repeat (5) @(negedge clk);
    tick = 1'b0;
    #1;
    n_cmp++; if (now !== 24'd5) begin n_err++; $display("FAIL tick5_now: got %0d want 5", now); end
    n_cmp++; if ({q_push, q_pop, q_drop, exp_valid} !== 4'd0) begin n_err++; $display("FAIL tick5_idle: got %b want 0", {q_push, q_pop, q_drop, exp_valid}); end
  endtask

  task automatic test_push_pop();
    do_reset();
    tick = 1'b1;
    repeat (3) @(negedge clk);
    tick = 1'b0;
    req_cell[0] = cell_t'{tag: 8'h00, id: 24'd1, data: 24'd10};
    req_valid   = 4'b0001;
    #1;
    n_cmp++; if (q_push !== 1'b1) begin n_err++; $display("FAIL push_strobe: got %b want 1", q_push); end
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL push_ready: got %b want 0001", req_ready); end
    n_cmp++; if (q_cell.data !== 24'd10) begin n_err++; $display("FAIL push_cell: got %0d want 10", q_cell.data); end
    @(negedge clk);
    req_valid = '0;
    q_empty   = 1'b0;
    q_head    = req_cell[0];
    #1;
    n_cmp++; if ({q_push, q_pop, q_drop} !== 3'b000) begin n_err++; $display("FAIL push_settle: got %b want 000", {q_push, q_pop, q_drop}); end
    tick = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    n_cmp++; if (now !== 24'd9) begin n_err++; $display("FAIL pp_now9: got %0d want 9", now); end
    n_cmp++; if (q_pop !== 1'b0) begin n_err++; $display("FAIL pp_early_pop: got %b want 0", q_pop); end
    @(negedge clk);
    tick = 1'b0;
    #1;
    n_cmp++; if (q_pop !== 1'b1) begin n_err++; $display("FAIL pp_due_pop: got %b want 1 (now=%0d)", q_pop, now); end
    @(negedge clk);
    q_empty = 1'b1;
    #1;
    n_cmp++; if (exp_valid !== 1'b1) begin n_err++; $display("FAIL pp_exp_valid: got %b want 1", exp_valid); end
    n_cmp++; if (exp_cell.data !== 24'd10) begin n_err++; $display("FAIL pp_exp_data: got %0d want 10", exp_cell.data); end
    n_cmp++; if (late_cnt !== 16'd0) begin n_err++; $display("FAIL pp_late: got %0d want 0", late_cnt); end
    @(negedge clk);
    #1;
    n_cmp++; if (exp_valid !== 1'b1 || exp_cell.id !== 24'd1) begin n_err++; $display("FAIL pp_exp_hold: got v=%b id=%0d want v=1 id=1", exp_valid, exp_cell.id); end
    exp_ready = 1'b1;
    @(negedge clk);
    exp_ready = 1'b0;
    #1;
    n_cmp++; if (exp_valid !== 1'b0) begin n_err++; $display("FAIL pp_exp_clear: got %b want 0", exp_valid); end
  endtask

  task automatic test_round_robin();
    int exp_idx[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < 4; i++) req_cell[i] = cell_t'{tag: 8'h00, id: 24'(i), data: 24'(100 + i)};
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 9; k++) begin
      logic [3:0] eg;
      if (k % 2 == 0) begin
        eg = 4'b0001 << exp_idx[k / 2];
        n_cmp++; if (req_ready !== eg || q_push !== 1'b1) begin n_err++; $display("FAIL rr_grant_c%0d: got ready=%b push=%b want ready=%b push=1", k, req_ready, q_push, eg); end
        n_cmp++; if (q_cell.data !== 24'(100 + exp_idx[k / 2])) begin n_err++; $display("FAIL rr_cell_c%0d: got %0d want %0d", k, q_cell.data, 100 + exp_idx[k / 2]); end
      end else begin
        n_cmp++; if (req_ready !== 4'b0000 || q_push !== 1'b0) begin n_err++; $display("FAIL rr_settle_c%0d: got ready=%b push=%b want 0", k, req_ready, q_push); end
      end
      @(negedge clk);
      #1;
    end
    req_valid = '0;
  endtask

  task automatic test_pop_drop_order();
    do_reset();
    tick = 1'b1;
    repeat (9) @(negedge clk);
    tick = 1'b0;
    q_empty     = 1'b0;
    q_head      = cell_t'{tag: 8'h00, id: 24'd44, data: 24'd4};
    drop_valid  = 1'b1;
    drop_id     = 24'd7;
    req_cell[0] = cell_t'{tag: 8'h00, id: 24'd55, data: 24'd50};
    req_valid   = 4'b0001;
    #1;
    n_cmp++; if ({q_pop, q_drop, drop_ready, q_push} !== 4'b1000) begin n_err++; $display("FAIL order_c0: got pop/drop/dr/push=%b want 1000", {q_pop, q_drop, drop_ready, q_push}); end
    @(negedge clk);
    q_head = cell_t'{tag: 8'h00, id: 24'd45, data: 24'd5};
    #1;
    n_cmp++; if ({q_pop, q_drop, q_push} !== 3'b000) begin n_err++; $display("FAIL order_c1: got %b want 000", {q_pop, q_drop, q_push}); end
    n_cmp++; if (exp_valid !== 1'b1 || exp_cell.id !== 24'd44) begin n_err++; $display("FAIL order_exp: got v=%b id=%0d want v=1 id=44", exp_valid, exp_cell.id); end
    @(negedge clk);
    #1;
    n_cmp++; if ({q_pop, q_drop, drop_ready, q_push} !== 4'b0110) begin n_err++; $display("FAIL order_c2: got %b want 0110", {q_pop, q_drop, drop_ready, q_push}); end
    n_cmp++; if (q_cell.id !== 24'd7 || q_cell.data !== 24'd0 || q_cell.tag !== 8'd0) begin n_err++; $display("FAIL order_drop_cell: got id=%0d data=%0d want id=7 data=0", q_cell.id, q_cell.data); end
    drop_valid = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if ({q_pop, q_drop, q_push} !== 3'b000) begin n_err++; $display("FAIL order_c3: got %b want 000", {q_pop, q_drop, q_push}); end
    @(negedge clk);
    #1;
    n_cmp++; if ({q_pop, q_push} !== 2'b01 || req_ready !== 4'b0001) begin n_err++; $display("FAIL order_c4: got pop/push=%b ready=%b want 01/0001", {q_pop, q_push}, req_ready); end
    req_valid = '0;
    @(negedge clk);
    #1;
    n_cmp++; if (late_cnt !== LATE_ONE) begin n_err++; $display("FAIL order_late: got %0d want %0d", late_cnt, LATE_ONE); end
    @(negedge clk);
    #1;
    n_cmp++; if (q_pop !== 1'b0 || exp_valid !== 1'b1) begin n_err++; $display("FAIL order_blocked: got pop=%b exp_valid=%b want 0/1", q_pop, exp_valid); end
    exp_ready = 1'b1;
    @(negedge clk);
    exp_ready = 1'b0;
    #1;
    n_cmp++; if (exp_valid !== 1'b0 || q_pop !== 1'b1) begin n_err++; $display("FAIL order_repop: got exp_valid=%b pop=%b want 0/1", exp_valid, q_pop); end
    q_empty = 1'b1;
    #1;
  endtask

  task automatic test_wrap();
    logic [23:0] heads [6] = '{24'hFFFFFE, 24'h800001, 24'h800002, 24'h000001, 24'h000002, 24'h000005};
    logic        dues  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    #1;
    n_cmp++; if (now !== 24'd1) begin n_err++; $display("FAIL wrap_now: got %0d want 1", now); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      q_head  = cell_t'{tag: 8'h00, id: 24'd0, data: heads[i]};
      q_empty = 1'b0;
      #1;
      n_cmp++; if (q_pop !== dues[i]) begin n_err++; $display("FAIL wrap_due_%0d: head=%h got pop=%b want %b", i, heads[i], q_pop, dues[i]); end
      q_empty = 1'b1;
      #1;
    end
  endtask

  task automatic test_full_reset();
    do_reset();
    tick = 1'b1;
    repeat (2) @(negedge clk);
    tick = 1'b0;
    q_full      = 1'b1;
    req_cell[0] = cell_t'{tag: 8'h00, id: 24'd9, data: 24'd90};
    req_valid   = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (req_ready !== 4'b0000 || q_push !== 1'b0) begin n_err++; $display("FAIL full_no_grant_%0d: got ready=%b push=%b want 0", i, req_ready, q_push); end
      @(negedge clk);
    end
    drop_valid = 1'b1;
    drop_id    = 24'd3;
    #1;
    n_cmp++; if (q_drop !== 1'b1 || drop_ready !== 1'b1) begin n_err++; $display("FAIL full_drop: got drop=%b ready=%b want 1/1", q_drop, drop_ready); end
    @(negedge clk);
    drop_valid = 1'b0;
    @(negedge clk);
    q_full = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0001 || q_push !== 1'b1) begin n_err++; $display("FAIL unfull_grant: got ready=%b push=%b want 0001/1", req_ready, q_push); end
    @(negedge clk);
    #1;
    n_cmp++; if (q_push !== 1'b0) begin n_err++; $display("FAIL unfull_settle: got %b want 0", q_push); end
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (now !== 24'd0 || exp_valid !== 1'b0 || late_cnt !== 16'd0) begin n_err++; $display("FAIL settle_rst_regs: got now=%0d exp_valid=%b late=%0d want 0", now, exp_valid, late_cnt); end
    n_cmp++; if ({q_push, q_pop, q_drop, drop_ready, req_ready} !== 8'd0) begin n_err++; $display("FAIL settle_rst_strobes: got %b want 0", {q_push, q_pop, q_drop, drop_ready, req_ready}); end
    drop_valid = 1'b1;
    #1;
    n_cmp++; if (q_drop !== 1'b1) begin n_err++; $display("FAIL settle_rst_idle: got drop=%b want 1", q_drop); end
    drop_valid = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_push_pop();
    test_round_robin();
    test_pop_drop_order();
    test_wrap();
    test_full_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
